// File: rtl/pcie_os_pkg.sv
// Shared ordered-set definitions for osDecoder, ts_os_checker and the LTSSM.
// Holds the symbol codes, bus geometry, OS type enums and the OS classifier.
package pcie_os_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    localparam int OS_BITS   = 128;
    localparam int MAX_LANES = 16;
    localparam int HIST_BITS = 42;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        TS1  = 2'd1,
        TS2  = 2'd2
    } os_type_e;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_SKP   = 2'd1,
        CLS_TS1   = 2'd2,
        CLS_TS2   = 2'd3
    } os_class_e;

    // COM must lead; SKP is decided on symbols 1..3 before any TS identifier check.
    function automatic os_class_e classify_os(input logic [OS_BITS-1:0] os);
        logic      all_ts1;
        logic      all_ts2;
        os_class_e cls;
        all_ts1 = 1'b1;
        all_ts2 = 1'b1;
        for (int k = 6; k < 16; k++) begin
            if (os[8*k +: 8] != TS1_ID) begin
                all_ts1 = 1'b0;
            end else begin
                all_ts1 = all_ts1;
            end
            if (os[8*k +: 8] != TS2_ID) begin
                all_ts2 = 1'b0;
            end else begin
                all_ts2 = all_ts2;
            end
        end
        if (os[7:0] != COM) begin
            cls = CLS_OTHER;
        end else if (os[15:8] == SKP && os[23:16] == SKP && os[31:24] == SKP) begin
            cls = CLS_SKP;
        end else if (all_ts1) begin
            cls = CLS_TS1;
        end else if (all_ts2) begin
            cls = CLS_TS2;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ts_lane_tracker.sv
// Per-lane TS tracker: classifies one OS, keeps the consecutive-identical count
// and the {type, sym1..5} history of the last accepted TS.
module ts_lane_tracker
    import pcie_os_pkg::*;
#(
    parameter int COUNT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               os_valid,
    input  logic               active,
    input  logic [OS_BITS-1:0] os,
    output logic [3:0]         next_count,
    output os_type_e           next_type,
    output logic               ts_load
);

    localparam logic [3:0] CNT_MAX = 4'(COUNT_MAX);

    logic [3:0]           count_r;
    logic [HIST_BITS-1:0] hist_r;
    logic [3:0]           count_next_s;
    logic [HIST_BITS-1:0] hist_next_s;
    logic [HIST_BITS-1:0] cand_hist_s;
    os_class_e            cls_s;
    logic                 load_s;

    // Next-state for count and history; SKP leaves both untouched.
    always_comb begin
        cls_s        = classify_os(os);
        count_next_s = count_r;
        hist_next_s  = hist_r;
        load_s       = 1'b0;
        if (cls_s == CLS_TS2) begin
            cand_hist_s = {TS2, os[47:8]};
        end else begin
            cand_hist_s = {TS1, os[47:8]};
        end
        if (clear) begin
            count_next_s = 4'd0;
            hist_next_s  = '0;
        end else if (os_valid) begin
            if (!active) begin
                count_next_s = 4'd0;
                hist_next_s  = '0;
            end else begin
                case (cls_s)
                    CLS_TS1, CLS_TS2: begin
                        load_s = 1'b1;
                        // An empty history has type NONE, so it never matches a candidate.
                        if (cand_hist_s == hist_r) begin
                            count_next_s = (count_r >= CNT_MAX) ? CNT_MAX : count_r + 4'd1;
                        end else begin
                            count_next_s = 4'd1;
                            hist_next_s  = cand_hist_s;
                        end
                    end
                    CLS_SKP: begin
                        count_next_s = count_r;
                        hist_next_s  = hist_r;
                    end
                    default: begin
                        count_next_s = 4'd0;
                        hist_next_s  = '0;
                    end
                endcase
            end
        end else begin
            count_next_s = count_r;
            hist_next_s  = hist_r;
        end
    end

    // Count and history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 4'd0;
            hist_r  <= '0;
        end else begin
            count_r <= count_next_s;
            hist_r  <= hist_next_s;
        end
    end

    assign next_count = count_next_s;
    assign next_type  = os_type_e'(hist_next_s[HIST_BITS-1 -: 2]);
    assign ts_load    = load_s;

endmodule

// File: rtl/ts_os_checker.sv
// Training-sequence checker between osDecoder and the LTSSM: per-lane TS run
// tracking, all-lanes TS1/TS2 received flags and lane-0 training field capture.
module ts_os_checker
    import pcie_os_pkg::*;
#(
    parameter int TS_COUNT  = 8,
    parameter int COUNT_MAX = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         osValid,
    input  logic [MAX_LANES*OS_BITS-1:0] osIn,
    input  logic [4:0]                   numberOfDetectedLanes,
    input  logic                         clear,
    output logic                         ts1Received,
    output logic                         ts2Received,
    output logic [7:0]                   rxLinkNumber,
    output logic [7:0]                   rxLaneNumber,
    output logic [7:0]                   rxNFTS,
    output logic [7:0]                   rxRate,
    output logic [7:0]                   rxTrainCtrl,
    output logic [15:0]                  padLinkMask
);

    localparam logic [3:0] TS_CNT = 4'(TS_COUNT);

    logic [4:0]           lanes_s;
    logic [MAX_LANES-1:0] active_s;
    logic [3:0]           next_count_s [MAX_LANES];
    os_type_e             next_type_s  [MAX_LANES];
    logic [MAX_LANES-1:0] ts_load_s;
    logic                 all_ts1_s;
    logic                 all_ts2_s;
    logic [15:0]          pad_next_s;

    // Lane-count decode; unsupported widths fall back to a single lane.
    always_comb begin
        case (numberOfDetectedLanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_s = numberOfDetectedLanes;
            default:                       lanes_s = 5'd1;
        endcase
        for (int l = 0; l < MAX_LANES; l++) begin
            active_s[l] = (5'(l) < lanes_s);
        end
    end

    for (genvar l = 0; l < MAX_LANES; l++) begin : g_lane
        ts_lane_tracker #(
            .COUNT_MAX (COUNT_MAX)
        ) u_trk (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .os_valid   (osValid),
            .active     (active_s[l]),
            .os         (osIn[OS_BITS*l +: OS_BITS]),
            .next_count (next_count_s[l]),
            .next_type  (next_type_s[l]),
            .ts_load    (ts_load_s[l])
        );
    end

    // All-active-lanes reduction on next-state counters, plus next PAD mask.
    always_comb begin
        all_ts1_s  = 1'b1;
        all_ts2_s  = 1'b1;
        pad_next_s = padLinkMask;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (active_s[l]) begin
                all_ts1_s = all_ts1_s & (next_type_s[l] == TS1) & (next_count_s[l] >= TS_CNT);
                all_ts2_s = all_ts2_s & (next_type_s[l] == TS2) & (next_count_s[l] >= TS_CNT);
            end else begin
                all_ts1_s = all_ts1_s;
                all_ts2_s = all_ts2_s;
            end
            if (ts_load_s[l]) begin
                pad_next_s[l] = (osIn[OS_BITS*l+8 +: 8] == PAD);
            end else begin
                pad_next_s[l] = padLinkMask[l];
            end
        end
    end

    // Received flags and PAD mask; cleared by clear, frozen while osValid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts1Received <= 1'b0;
            ts2Received <= 1'b0;
            padLinkMask <= 16'h0000;
        end else if (clear) begin
            ts1Received <= 1'b0;
            ts2Received <= 1'b0;
            padLinkMask <= 16'h0000;
        end else if (osValid) begin
            ts1Received <= all_ts1_s;
            ts2Received <= all_ts2_s;
            padLinkMask <= pad_next_s;
        end else begin
            ts1Received <= ts1Received;
            ts2Received <= ts2Received;
            padLinkMask <= padLinkMask;
        end
    end

    // Lane-0 training fields; survive clear, load only from a lane-0 TS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxLinkNumber <= 8'h00;
            rxLaneNumber <= 8'h00;
            rxNFTS       <= 8'h00;
            rxRate       <= 8'h00;
            rxTrainCtrl  <= 8'h00;
        end else if (ts_load_s[0]) begin
            rxLinkNumber <= osIn[15:8];
            rxLaneNumber <= osIn[23:16];
            rxNFTS       <= osIn[31:24];
            rxRate       <= osIn[39:32];
            rxTrainCtrl  <= osIn[47:40];
        end else begin
            rxLinkNumber <= rxLinkNumber;
            rxLaneNumber <= rxLaneNumber;
            rxNFTS       <= rxNFTS;
            rxRate       <= rxRate;
            rxTrainCtrl  <= rxTrainCtrl;
        end
    end

endmodule

// File: tb/tb_ts_os_checker.sv
// Directed bench for ts_os_checker: a run-length model checked every cycle,
// plus literal expectations for each training scenario.
module tb_ts_os_checker;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          osValid = 1'b0;
    logic          clear = 1'b0;
    logic [2047:0] osIn = '0;
    logic [4:0]    numberOfDetectedLanes = 5'd1;
    logic          ts1Received, ts2Received;
    logic [7:0]    rxLinkNumber, rxLaneNumber, rxNFTS, rxRate, rxTrainCtrl;
    logic [15:0]   padLinkMask;

    ts_os_checker dut (
        .clk                   (clk),
        .reset                 (reset),
        .osValid               (osValid),
        .osIn                  (osIn),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .clear                 (clear),
        .ts1Received           (ts1Received),
        .ts2Received           (ts2Received),
        .rxLinkNumber          (rxLinkNumber),
        .rxLaneNumber          (rxLaneNumber),
        .rxNFTS                (rxNFTS),
        .rxRate                (rxRate),
        .rxTrainCtrl           (rxTrainCtrl),
        .padLinkMask           (padLinkMask)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          m_run [16];
    logic [41:0] m_rec [16];
    logic        m_ts1, m_ts2;
    logic [39:0] m_fields;
    logic [15:0] m_pad;

    function automatic logic [127:0] mk_ts(input logic [7:0] id, input logic [7:0] link,
                                           input logic [7:0] lane, input logic [7:0] rate);
        logic [127:0] os;
        os = {16{id}};
        os[7:0]   = 8'hBC;
        os[15:8]  = link;
        os[23:16] = lane;
        os[31:24] = 8'h10;
        os[39:32] = rate;
        os[47:40] = 8'h00;
        return os;
    endfunction

    function automatic logic [127:0] mk_skp();
        logic [127:0] os;
        os = {16{8'h1C}};
        os[7:0] = 8'hBC;
        return os;
    endfunction

    task automatic fill(input logic [7:0] id, input logic [7:0] rate);
        for (int l = 0; l < 16; l++) osIn[128*l +: 128] = mk_ts(id, 8'h00, 8'(l), rate);
    endtask

    task automatic model_reset();
        for (int l = 0; l < 16; l++) begin
            m_run[l] = 0;
            m_rec[l] = '0;
        end
        m_ts1 = 1'b0; m_ts2 = 1'b0; m_fields = '0; m_pad = '0;
    endtask

    // 0 other, 1 SKP, 2 TS1, 3 TS2
    function automatic int kind_of(input logic [127:0] os);
        int n4a, n45;
        n4a = 0; n45 = 0;
        for (int k = 6; k < 16; k++) begin
            n4a += (os[8*k +: 8] == 8'h4A) ? 1 : 0;
            n45 += (os[8*k +: 8] == 8'h45) ? 1 : 0;
        end
        if (os[7:0] != 8'hBC) return 0;
        if (os[31:8] == {3{8'h1C}}) return 1;
        if (n4a == 10) return 2;
        if (n45 == 10) return 3;
        return 0;
    endfunction

    task automatic model_update();
        int n, kind, c;
        logic [127:0] os;
        logic [41:0] rec;
        if (clear) begin
            for (int l = 0; l < 16; l++) begin
                m_run[l] = 0;
                m_rec[l] = '0;
            end
            m_ts1 = 1'b0; m_ts2 = 1'b0; m_pad = '0;
        end else if (osValid) begin
            n = (numberOfDetectedLanes inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) ? int'(numberOfDetectedLanes) : 1;
            m_ts1 = 1'b1; m_ts2 = 1'b1;
            for (int l = 0; l < 16; l++) begin
                os = osIn[128*l +: 128];
                kind = kind_of(os);
                if (l >= n) begin
                    m_run[l] = 0; m_rec[l] = '0;
                end else if (kind >= 2) begin
                    rec = {(kind == 2) ? 2'd1 : 2'd2, os[47:8]};
                    if (rec == m_rec[l]) m_run[l]++;
                    else begin m_run[l] = 1; m_rec[l] = rec; end
                    m_pad[l] = (os[15:8] == 8'hF7);
                    if (l == 0) m_fields = os[47:8];
                end else if (kind == 0) begin
                    m_run[l] = 0; m_rec[l] = '0;
                end
                if (l < n) begin
                    c = (m_run[l] > 15) ? 15 : m_run[l];
                    if (!(m_rec[l][41:40] == 2'd1 && c >= 8)) m_ts1 = 1'b0;
                    if (!(m_rec[l][41:40] == 2'd2 && c >= 8)) m_ts2 = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [57:0] got, exp;
        got = {ts1Received, ts2Received, rxTrainCtrl, rxRate, rxNFTS, rxLaneNumber, rxLinkNumber, padLinkMask};
        exp = {m_ts1, m_ts2, m_fields, m_pad};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic clr);
        osValid = v;
        clear   = clr;
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic send(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        compare();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0);

        // 1: two lanes, eighth TS1 raises the flag
        numberOfDetectedLanes = 5'd2;
        fill(8'h4A, 8'h02);
        send(7);
        check("t1_before_8th", 16'(ts1Received), 16'h0000);
        send(1);
        check("t1_on_8th", 16'(ts1Received), 16'h0001);
        check("t1_rate", 16'(rxRate), 16'h0002);
        step(1'b0, 1'b1);

        // 2: four lanes, lane 2 changes rate after 7
        numberOfDetectedLanes = 5'd4;
        fill(8'h4A, 8'h02);
        send(7);
        osIn[256 +: 128] = mk_ts(8'h4A, 8'h00, 8'h02, 8'h06);
        send(1);
        check("t2_after_change", 16'(ts1Received), 16'h0000);
        send(6);
        check("t2_on_14th", 16'(ts1Received), 16'h0000);
        send(1);
        check("t2_on_15th", 16'(ts1Received), 16'h0001);
        step(1'b0, 1'b1);

        // 3: one lane, SKP interleaved in a TS2 run
        numberOfDetectedLanes = 5'd1;
        fill(8'h45, 8'h02);
        send(4);
        osIn[0 +: 128] = mk_skp();
        send(1);
        fill(8'h45, 8'h02);
        send(3);
        check("t3_on_8th", 16'(ts2Received), 16'h0000);
        send(1);
        check("t3_on_9th", 16'({ts1Received, ts2Received}), 16'h0001);
        step(1'b0, 1'b1);

        // 4: OTHER on lane 1 drops the flag; PAD link sets the mask
        numberOfDetectedLanes = 5'd2;
        fill(8'h4A, 8'h02);
        send(8);
        check("t4_raised", 16'(ts1Received), 16'h0001);
        osIn[128 +: 128] = '0;
        send(1);
        check("t4_fell", 16'(ts1Received), 16'h0000);
        osIn[128 +: 128] = mk_ts(8'h4A, 8'hF7, 8'h01, 8'h02);
        send(1);
        check("t4_pad", padLinkMask, 16'h0002);
        step(1'b0, 1'b1);
        check("t4_pad_cleared", padLinkMask, 16'h0000);

        // 5: clear coincides with the eighth TS1
        numberOfDetectedLanes = 5'd1;
        fill(8'h4A, 8'h03);
        send(7);
        step(1'b1, 1'b1);
        check("t5_clear_wins", 16'(ts1Received), 16'h0000);
        check("t5_rate_kept", 16'(rxRate), 16'h0003);
        send(7);
        check("t5_restart_7", 16'(ts1Received), 16'h0000);
        send(1);
        check("t5_restart_8", 16'(ts1Received), 16'h0001);
        step(1'b0, 1'b1);

        // 6: async reset mid-count
        send(5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t6_rate_zero", 16'(rxRate), 16'h0000);
        compare();
        @(negedge clk);
        reset = 1'b1;
        send(7);
        check("t6_after_7", 16'(ts1Received), 16'h0000);
        send(1);
        check("t6_after_8", 16'(ts1Received), 16'h0001);
        step(1'b0, 1'b1);

        // 7: unsupported lane count acts as one lane; idle cycles hold state
        numberOfDetectedLanes = 5'd3;
        fill(8'h4A, 8'h02);
        osIn[128 +: 128] = '0;
        send(8);
        check("t7_one_lane", 16'(ts1Received), 16'h0001);
        step(1'b0, 1'b0);
        check("t7_idle_hold", 16'(ts1Received), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
